// File: rtl/cond_detect_array.sv
// Multi-channel registered condition detector: input stage, per-channel persistence
// filter, sticky event flags and a round-robin valid/ready event reporter.
module cond_detect_array #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned NGRP    = 4,
  parameter int unsigned PERSIST = 2,
  localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned NG     = NCH * NGRP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NG*9-1:0] grp_bits,
  input  logic [NG*2-1:0] pair_bits,
  input  logic [NG-1:0]   grp_en,
  input  logic            clear,
  output logic [NCH-1:0]  level,
  output logic [NCH-1:0]  sticky,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_ch
);

  localparam int unsigned CNTW = $clog2(PERSIST + 1);

  typedef enum logic {IDLE, REPORT} state_t;

  logic [NG*9-1:0]  grp_q;
  logic [NG*2-1:0]  pair_q;
  logic [NG-1:0]    en_q;
  logic [NG-1:0]    gh;
  logic [NCH-1:0]   raw;
  logic [CNTW-1:0]  cnt      [NCH];
  logic [CNTW-1:0]  cnt_next [NCH];
  logic [NCH-1:0]   hit_next;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   hs_mask;
  logic [NCH-1:0]   sticky_next;
  state_t           state, state_next;
  logic [CW-1:0]    ptr, ptr_next, ch_next;
  logic             hs;
  logic             found;

  // Stage 1: raw inputs captured every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q  <= '0;
      pair_q <= '0;
      en_q   <= '0;
    end else begin
      grp_q  <= grp_bits;
      pair_q <= pair_bits;
      en_q   <= grp_en;
    end
  end

  for (genvar gi = 0; gi < int'(NG); gi++) begin : g_grp
    logic [8:0] b;
    logic [1:0] p;
    assign b = grp_q[gi*9 +: 9];
    assign p = pair_q[gi*2 +: 2];
    assign gh[gi] = en_q[gi] & ((p[0] & p[1]) |
                    (b[0] & ((b[1] & b[2]) | (b[3] & b[4] & b[5]) |
                             (b[3] & b[6] & b[7] & b[8]))));
  end

  // Persistence filter; level and sticky rise are decided from the next count
  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      raw[c] = |gh[c*NGRP +: NGRP];
      if (clear || !raw[c])                cnt_next[c] = '0;
      else if (cnt[c] < CNTW'(PERSIST))    cnt_next[c] = cnt[c] + CNTW'(1);
      else                                 cnt_next[c] = cnt[c];
      hit_next[c] = (cnt_next[c] == CNTW'(PERSIST));
    end
  end

  assign rise        = hit_next & ~level;
  assign hs_mask     = hs ? (NCH'(1) << out_ch) : '0;
  // A new rise beats a handshake clear; the clear input beats everything
  assign sticky_next = clear ? '0 : ((sticky & ~hs_mask) | rise);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(NCH); c++) cnt[c] <= '0;
      level  <= '0;
      sticky <= '0;
    end else begin
      for (int c = 0; c < int'(NCH); c++) cnt[c] <= cnt_next[c];
      level  <= hit_next;
      sticky <= sticky_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_next;
      out_valid <= (state_next == REPORT);
      out_ch    <= ch_next;
      ptr       <= ptr_next;
    end
  end

  // Reporter: round-robin pick from ptr, hold until handshake
  always_comb begin
    state_next = state;
    ch_next    = out_ch;
    ptr_next   = ptr;
    hs         = 1'b0;
    found      = 1'b0;
    case (state)
      IDLE: begin
        if (|sticky) begin
          for (int i = 0; i < int'(NCH); i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= int'(NCH)) j = j - int'(NCH);
            if (!found && sticky[j]) begin
              found   = 1'b1;
              ch_next = CW'(j);
            end
          end
          state_next = REPORT;
        end
      end
      REPORT: begin
        if (out_ready) begin
          hs         = 1'b1;
          state_next = IDLE;
          if (32'(out_ch) == NCH - 1) ptr_next = '0;
          else                        ptr_next = out_ch + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

endmodule

// File: tb/tb_cond_detect_array.sv
// Directed bench for cond_detect_array: default instance plus a PERSIST=1 instance
// sharing the same stimulus.
module tb_cond_detect_array;
  localparam int unsigned NCH  = 4;
  localparam int unsigned NGRP = 4;
  localparam int unsigned NG   = NCH * NGRP;

  logic            clk = 1'b0;
  logic            rst, clear, out_ready;
  logic [NG*9-1:0] grp_bits;
  logic [NG*2-1:0] pair_bits;
  logic [NG-1:0]   grp_en;
  logic [NCH-1:0]  level, sticky, level1, sticky1;
  logic            out_valid, out_valid1;
  logic [1:0]      out_ch, out_ch1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_detect_array #(.NCH(NCH), .NGRP(NGRP), .PERSIST(2)) dut (
    .clk(clk), .rst(rst), .grp_bits(grp_bits), .pair_bits(pair_bits),
    .grp_en(grp_en), .clear(clear), .level(level), .sticky(sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch));

  cond_detect_array #(.NCH(NCH), .NGRP(NGRP), .PERSIST(1)) dut1 (
    .clk(clk), .rst(rst), .grp_bits(grp_bits), .pair_bits(pair_bits),
    .grp_en(grp_en), .clear(clear), .level(level1), .sticky(sticky1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ch(out_ch1));

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_grp(input int c, input int g, input logic [8:0] b,
                         input logic [1:0] p, input logic en);
    grp_bits[(c*NGRP+g)*9 +: 9]  = b;
    pair_bits[(c*NGRP+g)*2 +: 2] = p;
    grp_en[c*NGRP+g]             = en;
  endtask

  task automatic clear_inputs();
    grp_bits  = '0;
    pair_bits = '0;
    grp_en    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    out_ready = 1'b0;
    clear = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
    clear_inputs();
    tick(2);
    chk("rst_level", 32'(level), 0);
    chk("rst_sticky", 32'(sticky), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ch", 32'(out_ch), 0);
    rst = 1'b0;

    // Ch1 group2 b0,b1,b2 held high
    set_grp(1, 2, 9'b000000111, 2'b00, 1'b1);
    tick(2);
    chk("t1_level_early", 32'(level), 0);
    tick();
    chk("t1_level", 32'(level), 4'b0010);
    chk("t1_sticky", 32'(sticky), 4'b0010);
    chk("t1_valid_early", 32'(out_valid), 0);
    tick();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_ch", 32'(out_ch), 1);
    out_ready = 1'b1;
    tick();
    chk("t1_hs_sticky", 32'(sticky), 0);
    chk("t1_hs_valid", 32'(out_valid), 0);
    chk("t1_hs_level", 32'(level), 4'b0010);
    out_ready = 1'b0;
    clear_inputs();
    tick(3);
    chk("t1_level_drop", 32'(level), 0);

    // Single-cycle pair pulse on ch0: filtered at PERSIST=2, reported at PERSIST=1
    do_reset();
    set_grp(0, 0, 9'd0, 2'b11, 1'b1);
    tick();
    clear_inputs();
    tick();
    chk("t2_level", 32'(level), 0);
    chk("t2_p1_level", 32'(level1), 4'b0001);
    chk("t2_p1_sticky", 32'(sticky1), 4'b0001);
    tick();
    chk("t2_p1_valid", 32'(out_valid1), 1);
    chk("t2_p1_ch", 32'(out_ch1), 0);
    chk("t2_p1_level_drop", 32'(level1), 0);
    chk("t2_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick();
    chk("t2_p1_hs_valid", 32'(out_valid1), 0);
    out_ready = 1'b0;
    tick(2);
    chk("t2_p1_one_report", 32'(out_valid1), 0);
    chk("t2_level_late", 32'(level), 0);
    chk("t2_sticky_late", 32'(sticky), 0);
    chk("t2_valid_late", 32'(out_valid), 0);

    // Enable gating on ch2
    do_reset();
    for (int g = 0; g < int'(NGRP); g++) set_grp(2, g, 9'h1FF, 2'b11, 1'b0);
    tick(5);
    chk("t3_gated_level", 32'(level), 0);
    chk("t3_gated_sticky", 32'(sticky), 0);
    grp_en[2*NGRP+3] = 1'b1;
    tick(3);
    chk("t3_sticky", 32'(sticky), 4'b0100);
    tick();
    chk("t3_valid", 32'(out_valid), 1);
    chk("t3_ch", 32'(out_ch), 2);
    out_ready = 1'b1;
    tick();
    chk("t3_hs_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Round-robin with backpressure: ch0 and ch3 together
    do_reset();
    set_grp(0, 0, 9'd0, 2'b11, 1'b1);
    set_grp(3, 1, 9'b000111001, 2'b00, 1'b1);
    tick(3);
    chk("t4_level", 32'(level), 4'b1001);
    chk("t4_sticky", 32'(sticky), 4'b1001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_bp_valid", 32'(out_valid), 1);
      chk("t4_bp_ch", 32'(out_ch), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_hs0_valid", 32'(out_valid), 0);
    chk("t4_hs0_sticky", 32'(sticky), 4'b1000);
    tick();
    chk("t4_rep3_valid", 32'(out_valid), 1);
    chk("t4_rep3_ch", 32'(out_ch), 3);
    tick();
    chk("t4_hs3_valid", 32'(out_valid), 0);
    chk("t4_hs3_sticky", 32'(sticky), 0);
    out_ready = 1'b0;
    pair_bits = '0; grp_bits = '0;
    tick(2);
    chk("t4_level_off", 32'(level), 0);
    set_grp(0, 0, 9'd0, 2'b11, 1'b1);
    set_grp(3, 1, 9'b000111001, 2'b00, 1'b1);
    tick(3);
    chk("t4_retrig_sticky", 32'(sticky), 4'b1001);
    tick();
    chk("t4_wrap_valid", 32'(out_valid), 1);
    chk("t4_wrap_ch", 32'(out_ch), 0);

    // Clear mid-report
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_valid", 32'(out_valid), 0);
    chk("t5_clr_sticky", 32'(sticky), 0);
    chk("t5_clr_level", 32'(level), 0);
    tick(2);
    chk("t5_again_sticky", 32'(sticky), 4'b1001);
    tick();
    chk("t5_again_valid", 32'(out_valid), 1);

    // Reset mid-report
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_sticky", 32'(sticky), 0);
    chk("t5_rst_level", 32'(level), 0);
    chk("t5_rst_ch", 32'(out_ch), 0);
    rst = 1'b0;

    // Handshake on ch1 coincides with a fresh level rise on ch1
    do_reset();
    set_grp(1, 0, 9'd0, 2'b11, 1'b1);
    tick(4);
    chk("t6_valid", 32'(out_valid), 1);
    chk("t6_ch", 32'(out_ch), 1);
    clear_inputs();
    tick(2);
    chk("t6_level_low", 32'(level), 0);
    chk("t6_hold_valid", 32'(out_valid), 1);
    chk("t6_hold_ch", 32'(out_ch), 1);
    set_grp(1, 0, 9'd0, 2'b11, 1'b1);
    tick(2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_race_level", 32'(level), 4'b0010);
    chk("t6_race_sticky", 32'(sticky), 4'b0010);
    chk("t6_race_valid", 32'(out_valid), 0);
    tick();
    chk("t6_rerep_valid", 32'(out_valid), 1);
    chk("t6_rerep_ch", 32'(out_ch), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
